// File: rtl/dbg_pkg.sv
// Shared types and default constants for the debug input conditioning block.
package dbg_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } dbg_state_t;

  localparam int DBG_SYNC_STAGES     = 2;
  localparam int DBG_DEBOUNCE_CYCLES = 500000;
  localparam int DBG_SEL_W           = 5;
  localparam int DBG_STEP_W          = 16;

endpackage

// File: rtl/dbg_input_cond_if.sv
// Raw board inputs in, conditioned debug levels and core enable out.
interface dbg_input_cond_if
  import dbg_pkg::*;
#(
  parameter int SEL_W = DBG_SEL_W
);

  logic                  sw_debug_raw;
  logic [SEL_W-1:0]      sw_sel_raw;
  logic                  btn_run_raw;
  logic                  btn_step_raw;

  logic                  debug;
  logic [SEL_W-1:0]      debug_input;
  logic                  sel_changed;
  logic                  core_en;
  logic                  halted;
  logic [DBG_STEP_W-1:0] step_cnt;

  // Board / stimulus side
  modport master (
    output sw_debug_raw, sw_sel_raw, btn_run_raw, btn_step_raw,
    input  debug, debug_input, sel_changed, core_en, halted, step_cnt
  );

  // Conditioner side
  modport slave (
    input  sw_debug_raw, sw_sel_raw, btn_run_raw, btn_step_raw,
    output debug, debug_input, sel_changed, core_en, halted, step_cnt
  );

endinterface

// File: rtl/dbg_debounce.sv
// Synchroniser + debounce for one channel; a vector is treated as a single channel.
module dbg_debounce #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  synced;
  logic [CNT_W-1:0]                  cnt_reg, cnt_next;
  logic [WIDTH-1:0]                  stable_reg, stable_next;
  logic                              changed_reg, changed_next;

  assign synced = sync_reg[SYNC_STAGES-1];

  // Counting is against the stable value, so a bounce back clears the count,
  // while a change between two non-stable values keeps counting.
  always_comb begin
    cnt_next     = cnt_reg;
    stable_next  = stable_reg;
    changed_next = 1'b0;
    if (synced == stable_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next     = '0;
      stable_next  = synced;
      changed_next = 1'b1;  // load only happens when synced differs from stable
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      sync_reg    <= '0;
      cnt_reg     <= '0;
      stable_reg  <= '0;
      changed_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], din};
      cnt_reg     <= cnt_next;
      stable_reg  <= stable_next;
      changed_reg <= changed_next;
    end
  end

  assign stable  = stable_reg;
  assign changed = changed_reg;

endmodule

// File: rtl/dbg_input_cond.sv
// Debounced debug switches plus run/halt/single-step control of the core clock enable.
module dbg_input_cond
  import dbg_pkg::*;
#(
  parameter int SYNC_STAGES     = DBG_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DBG_DEBOUNCE_CYCLES,
  parameter int SEL_W           = DBG_SEL_W
) (
  input  logic             clk,
  input  logic             Rst,
  dbg_input_cond_if.slave  io
);

  logic             debug_stable;
  logic [SEL_W-1:0] sel_stable;
  logic             sel_changed;
  logic             run_stable;
  logic             step_stable;
  logic [2:0]       unused_changed;

  dbg_debounce #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debug (
    .clk(clk), .Rst(Rst), .din(io.sw_debug_raw), .stable(debug_stable), .changed(unused_changed[0])
  );

  dbg_debounce #(.WIDTH(SEL_W), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk(clk), .Rst(Rst), .din(io.sw_sel_raw), .stable(sel_stable), .changed(sel_changed)
  );

  dbg_debounce #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk), .Rst(Rst), .din(io.btn_run_raw), .stable(run_stable), .changed(unused_changed[1])
  );

  dbg_debounce #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .Rst(Rst), .din(io.btn_step_raw), .stable(step_stable), .changed(unused_changed[2])
  );

  logic                  run_prev_reg, step_prev_reg;
  logic                  run_pulse, step_pulse;
  dbg_state_t            state_reg, state_next;
  logic                  core_en_reg, halted_reg;
  logic [DBG_STEP_W-1:0] step_cnt_reg;

  // Press edges only; releases are ignored
  assign run_pulse  = run_stable  & ~run_prev_reg;
  assign step_pulse = step_stable & ~step_prev_reg;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      HALT: begin
        if (run_pulse)       state_next = RUN;
        else if (step_pulse) state_next = STEP;
      end
      STEP:    state_next = HALT;
      RUN: begin
        if (run_pulse)       state_next = HALT;
      end
      default: state_next = HALT;
    endcase
  end

  // Enable and halted flags are registered from the next state so they track state_reg exactly
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_reg     <= HALT;
      core_en_reg   <= 1'b0;
      halted_reg    <= 1'b1;
      step_cnt_reg  <= '0;
      run_prev_reg  <= 1'b0;
      step_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      core_en_reg   <= (state_next != HALT);
      halted_reg    <= (state_next == HALT);
      run_prev_reg  <= run_stable;
      step_prev_reg <= step_stable;
      if (state_reg == STEP) step_cnt_reg <= step_cnt_reg + 1'b1;
    end
  end

  assign io.debug       = debug_stable;
  assign io.debug_input = sel_stable;
  assign io.sel_changed = sel_changed;
  assign io.core_en     = core_en_reg;
  assign io.halted      = halted_reg;
  assign io.step_cnt    = step_cnt_reg;

endmodule

// File: tb/tb_dbg_input_cond.sv
// Directed bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_dbg_input_cond;

  localparam int SEL_W = 5;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails  = 0;

  localparam int S_DEBUG = 0, S_SEL = 1, S_SELCHG = 2, S_CORE = 3, S_HALT = 4, S_CNT = 5;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t             exp_q[$];
  logic [SEL_W-1:0] sel_q[$];

  dbg_input_cond_if #(.SEL_W(SEL_W)) bus ();

  dbg_input_cond #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .SEL_W(SEL_W)) dut (
    .clk(clk),
    .Rst(Rst),
    .io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      S_DEBUG:  return {31'd0, bus.debug};
      S_SEL:    return {27'd0, bus.debug_input};
      S_SELCHG: return {31'd0, bus.sel_changed};
      S_CORE:   return {31'd0, bus.core_en};
      S_HALT:   return {31'd0, bus.halted};
      default:  return {16'd0, bus.step_cnt};
    endcase
  endfunction

  // Cycle-stamped scoreboard plus an event-driven check on every sel_changed pulse
  always @(negedge clk) begin : monitor
    logic [31:0] act;
    int          i;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].cyc == cyc) begin
        act = sample(exp_q[i].sig);
        checks++;
        if (act !== exp_q[i].val) begin
          fails++;
          $display("FAIL %s cyc %0d: got %h expected %h", exp_q[i].nm, cyc, act, exp_q[i].val);
        end else begin
          $display("ok   %s cyc %0d: %h", exp_q[i].nm, cyc, act);
        end
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        checks++;
        fails++;
        $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)", exp_q[i].nm, exp_q[i].cyc, cyc);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
    if (!Rst && bus.sel_changed === 1'b1) begin
      checks++;
      if (sel_q.size() == 0) begin
        fails++;
        $display("FAIL sel_changed_spurious cyc %0d: got pulse with debug_input %h, expected none", cyc, bus.debug_input);
      end else begin
        if (bus.debug_input !== sel_q[0]) begin
          fails++;
          $display("FAIL sel_changed_value cyc %0d: got %h expected %h", cyc, bus.debug_input, sel_q[0]);
        end else begin
          $display("ok   sel_changed_value cyc %0d: %h", cyc, bus.debug_input);
        end
        void'(sel_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_at(input int dc, input int sig, input logic [31:0] val, input string nm);
    exp_t e;
    e.cyc = cyc + dc;
    e.sig = sig;
    e.val = val;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.sw_debug_raw = 1'b0;
    bus.sw_sel_raw   = '0;
    bus.btn_run_raw  = 1'b0;
    bus.btn_step_raw = 1'b0;

    // 1. reset
    tick(2);
    Rst = 1'b0;
    expect_at(0, S_DEBUG, 0, "rst_debug");
    expect_at(0, S_SEL, 0, "rst_debug_input");
    expect_at(0, S_SELCHG, 0, "rst_sel_changed");
    expect_at(0, S_CORE, 0, "rst_core_en");
    expect_at(0, S_HALT, 1, "rst_halted");
    expect_at(0, S_CNT, 0, "rst_step_cnt");
    tick(3);

    // 2. select switches: 2 sync + 4 debounce cycles, then a 3-cycle glitch
    bus.sw_sel_raw = 5'h0A;
    sel_q.push_back(5'h0A);
    expect_at(5, S_SEL, 0, "sel_before_latency");
    expect_at(6, S_SEL, 32'h0A, "sel_at_latency");
    expect_at(6, S_SELCHG, 1, "sel_changed_pulse");
    expect_at(7, S_SELCHG, 0, "sel_changed_one_cycle");
    tick(10);
    bus.sw_sel_raw = 5'h1F;
    tick(3);
    bus.sw_sel_raw = 5'h0A;
    expect_at(9, S_SEL, 32'h0A, "sel_glitch_rejected");
    tick(10);

    // debug switch
    bus.sw_debug_raw = 1'b1;
    expect_at(5, S_DEBUG, 0, "debug_before_latency");
    expect_at(6, S_DEBUG, 1, "debug_at_latency");
    tick(8);

    // 3. single step from HALT, held button gives one step only
    bus.btn_step_raw = 1'b1;
    expect_at(6, S_CORE, 0, "step_core_en_pre");
    expect_at(7, S_CORE, 1, "step_core_en");
    expect_at(7, S_HALT, 0, "step_not_halted");
    expect_at(7, S_CNT, 0, "step_cnt_pre");
    expect_at(8, S_CORE, 0, "step_core_en_one_cycle");
    expect_at(8, S_HALT, 1, "step_halted_again");
    expect_at(8, S_CNT, 1, "step_cnt_1");
    expect_at(20, S_CNT, 1, "step_held_no_repeat");
    expect_at(20, S_CORE, 0, "step_held_core_en");
    tick(21);
    bus.btn_step_raw = 1'b0;
    expect_at(8, S_CNT, 1, "step_release_no_step");
    tick(9);

    // 4. run, step ignored in RUN, run again to halt
    bus.btn_run_raw = 1'b1;
    expect_at(6, S_CORE, 0, "run_core_en_pre");
    expect_at(7, S_CORE, 1, "run_core_en");
    expect_at(7, S_HALT, 0, "run_not_halted");
    tick(8);
    bus.btn_run_raw = 1'b0;
    expect_at(7, S_CORE, 1, "run_release_stays");
    tick(8);
    bus.btn_step_raw = 1'b1;
    expect_at(9, S_CNT, 1, "run_step_ignored");
    expect_at(9, S_CORE, 1, "run_step_core_en");
    tick(10);
    bus.btn_step_raw = 1'b0;
    tick(8);
    bus.btn_run_raw = 1'b1;
    expect_at(6, S_CORE, 1, "halt_core_en_pre");
    expect_at(7, S_CORE, 0, "halt_core_en");
    expect_at(7, S_HALT, 1, "halt_halted");
    tick(8);
    bus.btn_run_raw = 1'b0;
    tick(8);

    // 5. simultaneous run and step: run wins
    bus.btn_run_raw  = 1'b1;
    bus.btn_step_raw = 1'b1;
    expect_at(7, S_CORE, 1, "both_core_en");
    expect_at(7, S_HALT, 0, "both_not_halted");
    expect_at(8, S_CNT, 1, "both_step_cnt");
    expect_at(10, S_CORE, 1, "both_stay_run");
    tick(10);
    bus.btn_run_raw  = 1'b0;
    bus.btn_step_raw = 1'b0;
    tick(8);
    bus.btn_run_raw = 1'b1;
    expect_at(7, S_HALT, 1, "both_back_to_halt");
    tick(8);
    bus.btn_run_raw = 1'b0;
    tick(8);

    // step counter wrap via backdoor preload
    force dut.step_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.step_cnt_reg;
    tick(1);
    expect_at(0, S_CNT, 32'hFFFF, "wrap_preload");
    bus.btn_step_raw = 1'b1;
    expect_at(7, S_CORE, 1, "wrap_core_en");
    expect_at(8, S_CNT, 0, "wrap_step_cnt");
    expect_at(8, S_HALT, 1, "wrap_halted");
    tick(10);
    bus.btn_step_raw = 1'b0;
    tick(8);

    // 6. reset while in RUN with a select debounce count at 2
    bus.btn_run_raw = 1'b1;
    expect_at(7, S_CORE, 1, "pre_rst_run");
    tick(8);
    bus.btn_run_raw = 1'b0;
    tick(8);
    bus.sw_sel_raw = 5'h15;
    tick(4);
    expect_at(0, S_SEL, 32'h0A, "pre_rst_sel_counting");
    expect_at(0, S_DEBUG, 1, "pre_rst_debug");
    Rst = 1'b1;
    bus.sw_sel_raw   = '0;
    bus.sw_debug_raw = 1'b0;
    expect_at(1, S_HALT, 1, "rst_mid_halted");
    expect_at(1, S_CORE, 0, "rst_mid_core_en");
    expect_at(1, S_DEBUG, 0, "rst_mid_debug");
    expect_at(1, S_SEL, 0, "rst_mid_debug_input");
    expect_at(1, S_SELCHG, 0, "rst_mid_sel_changed");
    expect_at(1, S_CNT, 0, "rst_mid_step_cnt");
    tick(2);
    Rst = 1'b0;
    expect_at(10, S_SEL, 0, "post_rst_sel");
    expect_at(10, S_HALT, 1, "post_rst_halted");
    tick(12);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    checks++;
    if (sel_q.size() != 0) begin
      fails++;
      $display("FAIL sel_changed_missing: got %0d unmatched expected pulses, expected 0", sel_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
